instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Three-state instruction sequencer (IDLE -> FETCH -> EXEC). It fetches one
// instruction word from instruction memory, holds it for execution and then
// advances the program counter: sequentially, by a PC-relative branch offset,
// or by a region-local jump.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   run          enables fetching (sampled in IDLE and at the end of EXEC)
//   stall        holds EXEC while the data memory is busy
//   imem_req     instruction-memory read request (high in FETCH)
//   imem_addr    word address being fetched (always equal to pc)
//   imem_ack     imem_rdata valid this cycle (only honoured in FETCH)
//   imem_rdata   instruction word from memory
//   Branch       branch control bit (BNE: taken when Zero = 0)
//   Jump         jump control bit (takes priority over Branch)
//   Zero         ALU zero flag
//   pc           current program counter (word addressed)
//   instr        instruction register
//   OPCODE       instr[15:12], feeds the control unit
//   instr_valid  high exactly while in EXEC
//   retired_cnt  number of completed instructions (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        OPCODE,
  output logic              instr_valid,
  output logic [DATA_W-1:0] retired_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  // Sign-extend the 6-bit branch immediate to the full pc width.
  function automatic logic signed [DATA_W-1:0] sext_imm6(input logic [5:0] imm);
    sext_imm6 = {{(DATA_W-6){imm[5]}}, imm};
  endfunction

  logic [1:0]               state;
  logic [DATA_W-1:0]        pc_plus1;
  logic signed [DATA_W-1:0] br_off;
  logic [DATA_W-1:0]        br_target;
  logic [DATA_W-1:0]        jmp_target;
  logic [DATA_W-1:0]        pc_next;

  // Next-pc selection; all arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    pc_plus1   = pc + 1'b1;
    br_off     = sext_imm6(instr[5:0]);
    br_target  = pc_plus1 + $unsigned(br_off);
    jmp_target = {pc_plus1[DATA_W-1:12], instr[11:0]};
    pc_next    = pc_plus1;
    if (Jump)
      pc_next = jmp_target;
    else if (Branch && !Zero)
      pc_next = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run)
            state <= FETCH;
        end
        FETCH: begin
          // Wait indefinitely for the memory; ack elsewhere is ignored.
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc          <= pc_next;
            retired_cnt <= retired_cnt + 1'b1;
            state       <= run ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign OPCODE      = instr[15:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [3:0]  OPCODE;
  logic        instr_valid;
  logic [15:0] retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_ret;

  logic cnt_en = 1'b0;
  int   req_cycles = 0;
  int   valid_cycles = 0;

  instr_fetch_unit #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Branch(Branch), .Jump(Jump), .Zero(Zero),
    .pc(pc), .instr(instr), .OPCODE(OPCODE), .instr_valid(instr_valid),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: every retiring EXEC cycle pops one expected transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && stall === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 16'h0001, 16'h0000);
        end else begin
          e = sb.pop_front();
          chk("instr", instr, e.instr);
          chk("opcode", {12'h000, OPCODE}, {12'h000, e.instr[15:12]});
          chk("imem_req_in_exec", {15'h0, imem_req}, 16'h0000);
          @(negedge clk);
          chk("pc_after", pc, e.pc);
          chk("retired_after", retired_cnt, e.ret);
        end
      end
    end
  end

  // Cycle counters for the wait/stall scenario.
  always @(negedge clk) begin
    if (cnt_en) begin
      if (imem_req === 1'b1) req_cycles++;
      if (instr_valid === 1'b1) valid_cycles++;
    end
  end

  // Issue one instruction: drive the memory response and control bits,
  // push the expected outcome. Called at posedge+1 with the DUT in FETCH
  // or about to enter it.
  task automatic issue(input logic [15:0] rd, input logic br, input logic jmp,
                       input logic z, input int wait_n, input int stall_n,
                       input logic [15:0] exp_pc);
    exp_t e;
    int   guard;
    model_ret  = model_ret + 16'd1;
    e.instr    = rd;
    e.pc       = exp_pc;
    e.ret      = model_ret;
    sb.push_back(e);
    imem_rdata = rd;
    Branch     = br;
    Jump       = jmp;
    Zero       = z;
    imem_ack   = 1'b0;
    stall      = 1'b0;
    guard      = 0;
    while (imem_req !== 1'b1 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (imem_req !== 1'b1) chk("fetch_timeout", {15'h0, imem_req}, 16'h0001);
    repeat (wait_n) begin
      @(posedge clk); #1;
    end
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    imem_rdata = 16'h0000; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    model_ret = 16'h0000;

    // Reset with garbage on inputs must still clear everything.
    imem_ack = 1'b1; imem_rdata = 16'hBEEF; run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_retired", retired_cnt, 16'h0000);
    chk("rst_req", {15'h0, imem_req}, 16'h0000);
    chk("rst_valid", {15'h0, instr_valid}, 16'h0000);
    imem_ack = 1'b0; run = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_req", {15'h0, imem_req}, 16'h0000);

    run = 1'b1;
    issue(16'h2123, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0001);  // sequential
    issue(16'h3010, 1'b0, 1'b1, 1'b0, 0, 0, 16'h0010);  // jump within region 0
    chk("imem_addr", imem_addr, 16'h0010);
    issue(16'hE03E, 1'b1, 1'b0, 1'b0, 0, 0, 16'h000F);  // BNE taken, -2
    issue(16'h1000, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0010);  // sequential
    issue(16'hE03E, 1'b1, 1'b0, 1'b1, 0, 0, 16'h0011);  // BNE not taken
    issue(16'h4FFF, 1'b0, 1'b1, 1'b0, 0, 0, 16'h0FFF);  // jump
    issue(16'h5234, 1'b0, 1'b1, 1'b0, 0, 0, 16'h1234);  // pc_plus1 carries into region 1
    issue(16'hF056, 1'b1, 1'b1, 1'b0, 0, 0, 16'h1056);  // Jump beats Branch

    // Three ack-less wait cycles, then two stall cycles.
    req_cycles = 0; valid_cycles = 0; cnt_en = 1'b1;
    issue(16'h6001, 1'b0, 1'b0, 1'b0, 3, 2, 16'h1057);
    cnt_en = 1'b0;
    chk("req_cycles", 16'(req_cycles), 16'd4);
    chk("valid_cycles", 16'(valid_cycles), 16'd3);

    // Reset during a FETCH wait aborts the fetch.
    imem_ack = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_req", {15'h0, imem_req}, 16'h0001);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_ret = 16'h0000;
    chk("midrst_req", {15'h0, imem_req}, 16'h0000);
    chk("midrst_valid", {15'h0, instr_valid}, 16'h0000);
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_retired", retired_cnt, 16'h0000);

    // Negative wrap from 0, then forward wrap from 0xFFFF.
    issue(16'h703E, 1'b1, 1'b0, 1'b0, 0, 0, 16'hFFFF);
    run = 1'b0;
    issue(16'h8000, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);

    // run=0 at end of EXEC: IDLE, and ack there must not load instr.
    imem_rdata = 16'hABCD; imem_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("idle_after_run0_req", {15'h0, imem_req}, 16'h0000);
    chk("idle_after_run0_valid", {15'h0, instr_valid}, 16'h0000);
    chk("ack_ignored_instr", instr, 16'h8000);
    chk("idle_opcode", {12'h000, OPCODE}, 16'h0008);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
